// File: rtl/jogador_param.sv
// Per-player light-cycle controller: move tick, turn keys, head/direction, collision read, trail paint.
// Latency: one move per TICK_CYCLES in RUN, plus one CHECK cycle, the read round-trip and CELL*CELL granted writes.
// Backpressure: rd_req/rd_addr are held until rd_ack; wr_en/wr_addr/wr_data are held until wr_grant, with no timeout.
//
// Ports:
//   CLOCK_50, reset_n (async, active-low), restart (sync, active-high), start (level, leaves IDLE)
//   key_ccw, key_cw        active-low asynchronous turn buttons
//   rd_req/rd_addr/rd_ack/rd_data     arena read handshake for collision detection
//   wr_en/wr_addr/wr_data/wr_grant    trail framebuffer write handshake
//   pixel_x/pixel_y -> head_pixel     registered head overlay for the video mixer
//   head_x, head_y, dir, alive, game_over   player status
module jogador_param #(
  parameter int         CELL        = 8,
  parameter int         START_X     = 216,
  parameter int         START_Y     = 240,
  parameter int         START_DIR   = 0,
  parameter logic [7:0] PLAYER_ID   = 8'h01,
  parameter int         ARENA_MIN   = 16,
  parameter int         ARENA_MAX_X = 623,
  parameter int         ARENA_MAX_Y = 463,
  parameter int         TICK_CYCLES = 1000000,
  parameter int         H_RES       = 640,
  parameter int         ADDR_W      = 19
) (
  input  logic              CLOCK_50,
  input  logic              reset_n,
  input  logic              restart,
  input  logic              start,
  input  logic              key_ccw,
  input  logic              key_cw,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_grant,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  output logic              head_pixel,
  output logic [9:0]        head_x,
  output logic [9:0]        head_y,
  output logic [1:0]        dir,
  output logic              alive,
  output logic              game_over
);

  localparam int TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int CW = (CELL > 1) ? $clog2(CELL) : 1;

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0]     CELL_LAST = CW'(CELL - 1);
  localparam logic signed [10:0] CELL11   = 11'(CELL);
  localparam logic signed [11:0] CLAST12  = 12'(CELL - 1);
  localparam logic signed [11:0] AMIN12   = 12'(ARENA_MIN);
  localparam logic signed [11:0] AMAXX12  = 12'(ARENA_MAX_X);
  localparam logic signed [11:0] AMAXY12  = 12'(ARENA_MAX_Y);
  localparam logic [9:0]         CELL10   = 10'(CELL);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RUN   = 3'd1;
  localparam logic [2:0] S_CHECK = 3'd2;
  localparam logic [2:0] S_READ  = 3'd3;
  localparam logic [2:0] S_PAINT = 3'd4;
  localparam logic [2:0] S_DEAD  = 3'd5;

  logic [2:0]          state;
  logic [TW-1:0]       tick_cnt;
  logic [CW-1:0]       col;
  logic [CW-1:0]       row;
  logic signed [10:0]  tx;
  logic signed [10:0]  ty;
  logic                turned;
  logic [2:0]          ccw_sync;
  logic [2:0]          cw_sync;

  logic                ccw_fall;
  logic                cw_fall;
  logic                turn_take;
  logic [1:0]          dir_nxt;
  logic signed [10:0]  hx;
  logic signed [10:0]  hy;
  logic signed [10:0]  tgt_x;
  logic signed [10:0]  tgt_y;
  logic signed [11:0]  txe;
  logic signed [11:0]  tye;
  logic                oob;
  logic [9:0]          dx;
  logic [9:0]          dy;

  // Bits [0] and [1] are the synchroniser, bit [2] is the previous synced level.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      ccw_sync <= 3'b111;
      cw_sync  <= 3'b111;
    end else begin
      ccw_sync <= {ccw_sync[1:0], key_ccw};
      cw_sync  <= {cw_sync[1:0], key_cw};
    end
  end

  assign ccw_fall = ccw_sync[2] & ~ccw_sync[1];
  assign cw_fall  = cw_sync[2] & ~cw_sync[1];

  // Simultaneous edges cancel and do not use up this tick's turn.
  always_comb begin
    turn_take = 1'b0;
    dir_nxt   = dir;
    if (state == S_RUN && !turned && (ccw_fall ^ cw_fall)) begin
      turn_take = 1'b1;
      dir_nxt   = cw_fall ? dir + 2'd1 : dir - 2'd1;
    end
  end

  assign hx = {1'b0, head_x};
  assign hy = {1'b0, head_y};

  // A turn landing on the terminal tick already steers this move.
  always_comb begin
    tgt_x = hx;
    tgt_y = hy;
    case (dir_nxt)
      2'd0:    tgt_x = hx + CELL11;
      2'd1:    tgt_y = hy + CELL11;
      2'd2:    tgt_x = hx - CELL11;
      default: tgt_y = hy - CELL11;
    endcase
  end

  // Sign-extended so a move off the low edge compares as negative.
  assign txe = {tx[10], tx};
  assign tye = {ty[10], ty};
  assign oob = (txe < AMIN12) || (tye < AMIN12) ||
               ((txe + CLAST12) > AMAXX12) || ((tye + CLAST12) > AMAXY12);

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      head_x   <= 10'(START_X);
      head_y   <= 10'(START_Y);
      dir      <= 2'(START_DIR);
      tick_cnt <= '0;
      col      <= '0;
      row      <= '0;
      tx       <= 11'(START_X);
      ty       <= 11'(START_Y);
      turned   <= 1'b0;
    end else if (restart) begin
      state    <= S_IDLE;
      head_x   <= 10'(START_X);
      head_y   <= 10'(START_Y);
      dir      <= 2'(START_DIR);
      tick_cnt <= '0;
      col      <= '0;
      row      <= '0;
      tx       <= 11'(START_X);
      ty       <= 11'(START_Y);
      turned   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            // The start cell is painted directly, with no collision read.
            tx    <= hx;
            ty    <= hy;
            col   <= '0;
            row   <= '0;
            state <= S_PAINT;
          end
        end
        S_RUN: begin
          if (turn_take) begin
            dir    <= dir_nxt;
            turned <= 1'b1;
          end
          if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            tx       <= tgt_x;
            ty       <= tgt_y;
            state    <= S_CHECK;
          end else begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        S_CHECK: begin
          state <= oob ? S_DEAD : S_READ;
        end
        S_READ: begin
          if (rd_ack) begin
            col   <= '0;
            row   <= '0;
            state <= (rd_data != 8'd0) ? S_DEAD : S_PAINT;
          end
        end
        S_PAINT: begin
          if (wr_grant) begin
            if (col == CELL_LAST) begin
              col <= '0;
              if (row == CELL_LAST) begin
                row      <= '0;
                head_x   <= tx[9:0];
                head_y   <= ty[9:0];
                turned   <= 1'b0;
                tick_cnt <= '0;
                state    <= S_RUN;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        S_DEAD: begin
          state <= S_DEAD;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Unsigned wrap makes pixels left of / above the head compare as huge.
  assign dx = pixel_x - head_x;
  assign dy = pixel_y - head_y;

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      head_pixel <= 1'b0;
    end else if (restart) begin
      head_pixel <= 1'b0;
    end else begin
      head_pixel <= (state != S_IDLE) && (dx < CELL10) && (dy < CELL10);
    end
  end

  assign rd_req    = (state == S_READ);
  assign wr_en     = (state == S_PAINT);
  assign wr_data   = PLAYER_ID;
  assign rd_addr   = ADDR_W'(tx[9:0]) + ADDR_W'(ty[9:0]) * ADDR_W'(H_RES);
  assign wr_addr   = ADDR_W'(tx[9:0]) + ADDR_W'(col) +
                     (ADDR_W'(ty[9:0]) + ADDR_W'(row)) * ADDR_W'(H_RES);
  assign alive     = (state == S_RUN) || (state == S_CHECK) ||
                     (state == S_READ) || (state == S_PAINT);
  assign game_over = (state == S_DEAD);

endmodule
